anel_torcido_ctrl: RTL and testbench
====================================

ANEL_TORCIDO_CTRL -- requirements
Module: anel_torcido_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 5, ring length in bits (legal range 2..8).
REQ-002 Port clk SHALL be: clk  input  1  rising-edge clock, sole clock.
REQ-003 Port clear SHALL be: clear  input  1  asynchronous active-high reset.
REQ-004 Port start SHALL be: start  input  1  begin a run (sampled in IDLE only).
REQ-005 Port stop SHALL be: stop  input  1  abort a run (sampled in RUN only).
REQ-006 Port dir SHALL be: dir  input  1  0 = forward, 1 = reverse; sampled each RUN step.
REQ-007 Port steps SHALL be: steps  input  4  step count latched at start; 0 = free-run.
REQ-008 Port load SHALL be: load  input  1  load load_val into ring (IDLE only).
REQ-009 Port load_val SHALL be: load_val  input  WIDTH  pattern to load.
REQ-010 Port q SHALL be: q  output  WIDTH  twisted-ring (Johnson) state.
REQ-011 Port busy SHALL be: busy  output  1  high while in RUN.
REQ-012 Port done SHALL be: done  output  1  one-cycle pulse after a counted run ends or is stopped.
REQ-013 Port err SHALL be: err  output  1  sticky illegal-pattern flag.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE, FIX; all outputs registered.
REQ-015 Forward step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; reverse step SHALL be q <= {~q[0], q[WIDTH-1:1]}.
REQ-016 IDLE with start=1 SHALL go to RUN at that edge, latch steps into a 4-bit down-counter, q unchanged.
REQ-017 Each edge in RUN SHALL perform one step; counter decrements; step at counter==1 SHALL transition to DONE.
REQ-018 steps=0 SHALL run indefinitely, counter not decremented, until stop.
REQ-019 stop=1 in RUN SHALL go to DONE with no step that edge; stop SHALL take priority over the final step.
REQ-020 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-021 start and load both high in IDLE: load SHALL win, start ignored.
REQ-022 start, load, stop outside their sampling state SHALL be ignored.
REQ-023 Latency: start at edge N, steps=k>0 -> k steps at edges N+1..N+k, done=1 in cycle after N+k, busy low from edge N+k.

Reset
REQ-024 clear=1 SHALL immediately force state=IDLE, q=0, counter=0, busy=0, done=0, err=0, regardless of clk, including mid-run.
REQ-025 Release of clear SHALL resume in IDLE on the next edge with no spurious done.

Configuration
REQ-026 Macro ANEL_CHECK_EN defined: any illegal Johnson pattern on q (after load or in any state) SHALL set err and send FSM to FIX, which forces q=0 in one cycle then enters IDLE (done not asserted).
REQ-027 Macro ANEL_CHECK_EN undefined: err SHALL be tied 0, FIX state absent, illegal patterns circulate unchanged.

Structure
REQ-028 Package anel_pkg SHALL hold the state enum, default WIDTH constant, and functions johnson_next(q,dir) and johnson_legal(q).
REQ-029 One sub-module anel_johnson_reg SHALL implement the WIDTH-bit ring register with load, step enable, direction, synchronous zero, and async clear.

Verification
REQ-030 clear, load_val=5'b00000, start with steps=3, dir=0 -> q 00001, 00011, 00111 on consecutive edges; done pulse one cycle; busy high 3 cycles.
REQ-031 steps=0, dir=0, 10 edges from 00000 -> q returns to 00000 (period 2*WIDTH); stop -> done pulse, q frozen.
REQ-032 load 5'b11100, start steps=2, dir=1 -> q 11110 then 11111; then IDLE.
REQ-033 ANEL_CHECK_EN set, load 5'b10101 -> err=1 next cycle, q=00000 one cycle later, FSM IDLE, err sticky until clear.
REQ-034 clear asserted mid-run between edges -> q=00000, busy=0, done=0 immediately; no done after release.
REQ-035 start and stop together in RUN with counter==1 -> no step, DONE entered, q unchanged.

Source files
------------

// File: rtl/anel_pkg.sv
// Shared types and ring helpers for the twisted-ring controller.
// Optional ANEL_CHECK_EN adds the FIX state used for illegal-pattern recovery.
package anel_pkg;

  localparam int unsigned WIDTH_DEF = 5;
  localparam int unsigned WMAX      = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef ANEL_CHECK_EN
    ,
    S_FIX  = 2'd3
`endif
  } state_t;

  // One Johnson step on the low msb+1 bits; upper bits return zero.
  function automatic logic [WMAX-1:0] johnson_next(
    input logic [WMAX-1:0] q,
    input logic            dir,
    input logic [2:0]      msb
  );
    logic [WMAX-1:0] n;
    logic [WMAX-1:0] m;
    m = '0;
    for (int i = 0; i < WMAX; i++) begin
      if (i <= int'(msb)) m[i] = 1'b1;
    end
    if (!dir) begin
      n      = q << 1;
      n[0]   = ~q[msb];
    end else begin
      n      = q >> 1;
      n[msb] = ~q[0];
    end
    return n & m;
  endfunction

  // Legal Johnson words have at most one 0/1 boundary.
  function automatic logic johnson_legal(
    input logic [WMAX-1:0] q,
    input logic [2:0]      msb
  );
    logic [3:0] t;
    t = '0;
    for (int i = 0; i < WMAX - 1; i++) begin
      if (i < int'(msb) && q[i] != q[i+1]) t = t + 4'd1;
    end
    return t <= 4'd1;
  endfunction

endpackage

// File: rtl/anel_torcido_ctrl_if.sv
// Command/status bundle of the twisted-ring controller.
// master drives commands and watches status; slave is the controller side.
interface anel_torcido_ctrl_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic             stop;
  logic             dir;
  logic [3:0]       steps;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, dir, steps, load, load_val,
    input  q, busy, done, err
  );

  modport slave (
    input  start, stop, dir, steps, load, load_val,
    output q, busy, done, err
  );
endinterface

// File: rtl/anel_johnson_reg.sv
// WIDTH-bit Johnson ring: sync zero > load > step, async clear to zero.
// Ports: clk, clear, load/load_val, step, dir, zero, q.
module anel_johnson_reg
  import anel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             dir,
  input  logic             zero,
  output logic [WIDTH-1:0] q
);

  localparam logic [2:0] MSB = 3'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WMAX-1:0]  qx;
  logic [WMAX-1:0]  nx;
  logic             unused_nx;

  always_comb begin
    qx            = '0;
    qx[WIDTH-1:0] = q_q;
    nx            = johnson_next(qx, dir, MSB);
    q_d           = q_q;
    if (zero)      q_d = '0;
    else if (load) q_d = load_val;
    else if (step) q_d = nx[WIDTH-1:0];
  end

  assign unused_nx = ^nx;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/anel_torcido_ctrl.sv
// Twisted-ring run controller: IDLE/RUN/DONE (+FIX with ANEL_CHECK_EN).
// Ports: clk, clear, start, stop, dir, steps, load, load_val -> q, busy, done, err.
module anel_torcido_ctrl
  import anel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [3:0]       steps,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       r_load, r_step, r_zero;

`ifdef ANEL_CHECK_EN
  localparam logic [2:0] MSB = 3'(WIDTH - 1);
  logic            err_q, err_d;
  logic [WMAX-1:0] qx;
  logic            bad;

  always_comb begin
    qx            = '0;
    qx[WIDTH-1:0] = q;
    bad           = !johnson_legal(qx, MSB);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_load  = 1'b0;
    r_step  = 1'b0;
    r_zero  = 1'b0;
`ifdef ANEL_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          r_load = 1'b1;
        end else if (start) begin
          state_d = S_RUN;
          cnt_d   = steps;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          r_step = 1'b1;
          // zero count means free-run: never decremented
          if (cnt_q == 4'd1) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else if (cnt_q != 4'd0) begin
            cnt_d = 4'(cnt_q - 4'd1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef ANEL_CHECK_EN
      S_FIX: begin
        r_zero  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef ANEL_CHECK_EN
    // an illegal ring word overrides whatever the state wanted
    if (bad && state_q != S_FIX) begin
      state_d = S_FIX;
      err_d   = 1'b1;
      cnt_d   = '0;
      r_load  = 1'b0;
      r_step  = 1'b0;
    end
`endif
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ANEL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ANEL_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  anel_johnson_reg #(.WIDTH(WIDTH)) u_ring (
    .clk      (clk),
    .clear    (clear),
    .load     (r_load),
    .load_val (load_val),
    .step     (r_step),
    .dir      (dir),
    .zero     (r_zero),
    .q        (q)
  );

  assign busy = busy_q;
  assign done = done_q;
`ifdef ANEL_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_anel_torcido_ctrl.sv
// Scoreboard bench for anel_torcido_ctrl (WIDTH=5).
// Driver pushes model expectations; negedge monitor pops and compares.
module tb_anel_torcido_ctrl;

  localparam int W = 5;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  anel_torcido_ctrl_if #(.WIDTH(W)) bus ();

  anel_torcido_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (bus.start),
    .stop     (bus.stop),
    .dir      (bus.dir),
    .steps    (bus.steps),
    .load     (bus.load),
    .load_val (bus.load_val),
    .q        (bus.q),
    .busy     (bus.busy),
    .done     (bus.done),
    .err      (bus.err)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         err;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // reference: mode 0 idle, 1 running, 2 done pulse, 3 repair
  int           m_mode = 0;
  int           m_left = 0;
  logic [W-1:0] m_q    = '0;
  logic         m_err  = 1'b0;
  bit           legal[int];
  int           legal_v[$];

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input logic d);
    int x;
    x = int'(v);
    if (!d) x = ((x << 1) | (((x >> (W - 1)) & 1) ^ 1)) & MASK;
    else    x = (x >> 1) | (((x & 1) ^ 1) << (W - 1));
    return W'(x);
  endfunction

  function automatic void model_edge(
    input logic c, st, sp, d, input logic [3:0] n,
    input logic ld, input logic [W-1:0] lv);
    if (c) begin
      m_mode = 0; m_q = '0; m_left = 0; m_err = 1'b0;
      return;
    end
`ifdef ANEL_CHECK_EN
    if (m_mode != 3 && !legal.exists(int'(m_q))) begin
      m_err = 1'b1; m_mode = 3;
      return;
    end
`endif
    case (m_mode)
      0: begin
        if (ld) m_q = lv;
        else if (st) begin m_left = int'(n); m_mode = 1; end
      end
      1: begin
        if (sp) m_mode = 2;
        else begin
          m_q = ref_step(m_q, d);
          if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
          end
        end
      end
      2: m_mode = 0;
      default: begin m_q = '0; m_mode = 0; end
    endcase
  endfunction

  function automatic void push_exp(input string tag);
    exp_t e;
    e.q = m_q; e.busy = (m_mode == 1); e.done = (m_mode == 2);
    e.err = m_err; e.tag = tag;
    sbq.push_back(e);
  endfunction

  // apply one cycle of inputs (called just after a negedge)
  task automatic tick(
    input logic c, st, sp, d, input logic [3:0] n,
    input logic ld, input logic [W-1:0] lv, input string tag);
    clear = c; bus.start = st; bus.stop = sp; bus.dir = d;
    bus.steps = n; bus.load = ld; bus.load_val = lv;
    model_edge(c, st, sp, d, n, ld, lv);
    push_exp(tag);
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic d, input string tag);
    tick(1'b0, 1'b0, 1'b0, d, 4'd0, 1'b0, '0, tag);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if ({bus.q, bus.busy, bus.done, bus.err} !== {e.q, e.busy, e.done, e.err}) begin
        failures++;
        $display("FAIL %s: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                 e.tag, bus.q, bus.busy, bus.done, bus.err, e.q, e.busy, e.done, e.err);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 2 * W; i++) begin
      legal[int'(v)] = 1'b1;
      legal_v.push_back(int'(v));
      v = ref_step(v, 1'b0);
    end

    clear = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0;
    bus.steps = '0; bus.load = 1'b0; bus.load_val = '0;
    @(negedge clk); #1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0, "reset");

    // counted forward run of 3
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'b00000, "ld0");
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, '0, "start3");
    for (int i = 0; i < 3; i++) idle(1'b0, "run3");
    idle(1'b0, "after3");

    // free run wraps after 2*W, then stop
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0, "start_free");
    for (int i = 0; i < 10; i++) idle(1'b0, "free");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, '0, "stop_free");
    idle(1'b0, "after_stop");

    // reverse run of 2 from 11100
    tick(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 5'b11100, "ld11100");
    tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, '0, "start_rev");
    for (int i = 0; i < 2; i++) idle(1'b1, "rev");
    idle(1'b1, "after_rev");

    // load beats start
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 5'b00011, "ld_vs_start");
    idle(1'b0, "ld_won");

    // stop beats final step
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, '0, "start1");
    tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, '0, "stop_last");
    idle(1'b0, "after_stop_last");

    // asynchronous clear mid-run, between edges
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0, "start_clr");
    for (int i = 0; i < 3; i++) idle(1'b0, "pre_clr");
    clear = 1'b1;
    #1;
    checks++;
    if (bus.q !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: got q=%b busy=%b done=%b err=%b want all zero",
               bus.q, bus.busy, bus.done, bus.err);
    end
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, '0);
    push_exp("clr_hold");
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) idle(1'b0, "post_clr");

`ifdef ANEL_CHECK_EN
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 5'b10101, "ld_bad");
    for (int i = 0; i < 3; i++) idle(1'b0, "fix");
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic         c, st, sp, d, ld;
      logic [3:0]   n;
      logic [W-1:0] lv;
      c  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      sp = ($urandom_range(0, 99) < 10);
      ld = ($urandom_range(0, 99) < 15);
      d  = 1'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) lv = W'($urandom);
      else lv = W'(legal_v[$urandom_range(0, 2 * W - 1)]);
      tick(c, st, sp, d, n, ld, lv, "rand");
    end

    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
